// File: rtl/sram_arb_2x1_if.sv
// rtl/sram_arb_2x1_if.sv - SRAM-like request/response bus shared by masters, arbiter and slave
//
// Purpose: bundles one SRAM-like port (request channel plus decoupled response).
// Modports:
//   master - drives req/wr/size/addr/wdata; receives rdata/addr_ok/data_ok
//   slave  - receives req/wr/size/addr/wdata; drives rdata/addr_ok/data_ok
interface sram_arb_2x1_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (
    output req, wr, size, addr, wdata,
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output rdata, addr_ok, data_ok
  );
endinterface

// File: rtl/sram_arb_2x1.sv
// rtl/sram_arb_2x1.sv - merges instruction and data SRAM-like masters onto one slave
//
// Purpose: fixed-priority (data over inst) 2:1 arbiter. Requests pass straight
// through to the slave with no added latency; an owner FIFO records which master
// each accepted request belongs to so that decoupled responses are steered back
// in order.
// Ports:
//   clk, resetn - clock, asynchronous active-low reset
//   inst        - slave side of the instruction master's bus
//   data        - slave side of the data master's bus
//   mem         - master side of the shared memory bus
module sram_arb_2x1 #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic            clk,
  input  logic            resetn,
  sram_arb_2x1_if.slave   inst,
  sram_arb_2x1_if.slave   data,
  sram_arb_2x1_if.master  mem
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

  // A presented-but-unaccepted request pins the grant to its owner so that the
  // slave never sees the request switch underneath it.
  typedef enum logic [1:0] {
    ST_OPEN      = 2'd0,
    ST_LOCK_INST = 2'd1,
    ST_LOCK_DATA = 2'd2
  } lock_state_e;

  lock_state_e state_q, state_d;

  logic [DEPTH-1:0] owner_q;   // 1 = data, 0 = inst
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;

  logic full;
  logic sel_inst;
  logic sel_data;
  logic push;
  logic pop;
  logic head_owner;

  assign full       = (count_q == CNT_FULL);
  assign head_owner = owner_q[rd_ptr_q];

  // Selection and lock next-state. Outputs are forced to zero while reset is
  // asserted, so a master holding req during reset reaches nothing.
  always_comb begin
    sel_inst = 1'b0;
    sel_data = 1'b0;
    state_d  = state_q;
    case (state_q)
      ST_OPEN: begin
        if (!full) begin
          if (data.req)      sel_data = 1'b1;
          else if (inst.req) sel_inst = 1'b1;
        end
      end
      ST_LOCK_INST: sel_inst = 1'b1;
      ST_LOCK_DATA: sel_data = 1'b1;
      default: ;
    endcase
    if (!resetn) begin
      sel_inst = 1'b0;
      sel_data = 1'b0;
    end

    if (mem.addr_ok) begin
      state_d = ST_OPEN;
    end else if (sel_data && data.req) begin
      state_d = ST_LOCK_DATA;
    end else if (sel_inst && inst.req) begin
      state_d = ST_LOCK_INST;
    end
  end

  always_comb begin
    mem.req   = 1'b0;
    mem.wr    = 1'b0;
    mem.size  = 2'd0;
    mem.addr  = 32'd0;
    mem.wdata = 32'd0;
    if (sel_data) begin
      mem.req   = data.req;
      mem.wr    = data.wr;
      mem.size  = data.size;
      mem.addr  = data.addr;
      mem.wdata = data.wdata;
    end else if (sel_inst) begin
      mem.req   = inst.req;
      mem.wr    = inst.wr;
      mem.size  = inst.size;
      mem.addr  = inst.addr;
      mem.wdata = inst.wdata;
    end
  end

  assign push = mem.req & mem.addr_ok;
  // A response with nothing outstanding (e.g. left over from before a reset) is dropped.
  assign pop  = resetn & mem.data_ok & (count_q != '0);

  assign data.addr_ok = push & sel_data;
  assign inst.addr_ok = push & sel_inst;

  assign data.data_ok = pop & head_owner;
  assign inst.data_ok = pop & ~head_owner;
  assign data.rdata   = resetn ? mem.rdata : 32'd0;
  assign inst.rdata   = resetn ? mem.rdata : 32'd0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_OPEN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        owner_q[wr_ptr_q] <= sel_data;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
